// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {RUN, REDIRECT, MDU_WAIT} ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX hazard inputs in, stage-register controls out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_mem_read, ex_branch_taken, ex_mdu_start, mdu_done;
  logic             pc_write, hold, IF_flush, id_ex_flush, ex_hold, mdu_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mdu_start, mdu_done,
    input  pc_write, hold, IF_flush, id_ex_flush, ex_hold, mdu_timeout, stall_cnt
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_mdu_start, mdu_done,
    output pc_write, hold, IF_flush, id_ex_flush, ex_hold, mdu_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detect; kept separate so a forwarding unit can reuse it.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mem_read,
  output logic             o_lu
);
  logic w_hit1, w_hit2;

  assign w_hit1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_hit2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is never a real producer, so a load to x0 cannot create a hazard
  assign o_lu   = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_hit1 || w_hit2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID, ID/EX and EX/MEM sequencer: load-use bubbles, branch squash, MDU stall,
// plus a saturating stall counter and sticky MDU timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MDU_TIMEOUT      = 64,
  parameter int CNT_W            = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int TO_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MDU_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  ctrl_state_t      r_state, w_state_nxt;
  logic [2:0]       r_bub, w_bub_nxt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;
  logic             w_pc_write, w_hold, w_if_flush, w_id_ex_flush, w_ex_hold;

  load_use_detect u_lu (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_use_rs1  (bus.id_use_rs1),
    .i_id_use_rs2  (bus.id_use_rs2),
    .i_ex_rd       (bus.ex_rd),
    .i_ex_mem_read (bus.ex_mem_read),
    .o_lu          (w_lu)
  );

  // Mealy outputs so a hazard is answered in the same cycle it appears
  always_comb begin
    w_pc_write    = 1'b1;
    w_hold        = 1'b0;
    w_if_flush    = 1'b0;
    w_id_ex_flush = 1'b0;
    w_ex_hold     = 1'b0;
    w_state_nxt   = r_state;
    w_bub_nxt     = r_bub;
    if (rst) begin
      w_pc_write    = 1'b0;
      w_hold        = 1'b1;
      w_if_flush    = 1'b1;
      w_id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.ex_branch_taken) begin
            w_hold        = 1'b1;
            w_if_flush    = 1'b1;
            w_id_ex_flush = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
              w_state_nxt = REDIRECT;
              w_bub_nxt   = 3'(REDIRECT_BUBBLES - 1);
            end
          end else if (bus.ex_mdu_start) begin
            w_pc_write  = 1'b0;
            w_hold      = 1'b1;
            w_ex_hold   = 1'b1;
            w_state_nxt = MDU_WAIT;
          end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_hold        = 1'b1;
            w_id_ex_flush = 1'b1;
          end
        end
        REDIRECT: begin
          w_hold        = 1'b1;
          w_if_flush    = 1'b1;
          w_id_ex_flush = 1'b1;
          if (r_bub == 3'd0) w_state_nxt = RUN;
          else               w_bub_nxt   = r_bub - 3'd1;
        end
        MDU_WAIT: begin
          if (bus.mdu_done) begin
            w_state_nxt = RUN;
          end else begin
            w_pc_write = 1'b0;
            w_hold     = 1'b1;
            w_ex_hold  = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_bub       <= 3'd0;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bub   <= w_bub_nxt;
      if (r_state == RUN && w_state_nxt == MDU_WAIT) begin
        r_to_cnt <= '0;
      end else if (r_state == MDU_WAIT && !bus.mdu_done) begin
        if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TO_W'(1);
        if (r_to_cnt >= TO_LAST) r_timeout <= 1'b1;
      end
      if (!w_pc_write && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.hold        = w_hold;
  assign bus.IF_flush    = w_if_flush;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.ex_hold     = w_ex_hold;
  assign bus.mdu_timeout = r_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int RB    = 2;
  localparam int TMO   = 8;
  localparam int CNT_W = 7;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .REDIRECT_BUBBLES (RB),
    .MDU_TIMEOUT      (TMO),
    .CNT_W            (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: remaining squash cycles, MDU busy + waited cycles, flag, stall count
  int m_squash = 0;
  bit m_busy   = 1'b0;
  int m_wait   = 0;
  bit m_to     = 1'b0;
  int m_stall  = 0;
  bit m_valid  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock: drive, check the cycle's outputs against the model, advance
  task automatic cycle(input bit r, input bit br, input bit ms, input bit dn,
                       input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2);
    logic [4:0] exp;
    bit lu;
    rst = r;
    bus.ex_branch_taken = br; bus.ex_mdu_start = ms; bus.mdu_done = dn;
    bus.ex_mem_read = mr; bus.ex_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    #1;
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // {pc_write, hold, IF_flush, id_ex_flush, ex_hold}
    if (r)                 exp = 5'b01110;
    else if (m_squash > 0) exp = 5'b11110;
    else if (m_busy)       exp = dn ? 5'b10000 : 5'b01001;
    else if (br)           exp = 5'b11110;
    else if (ms)           exp = 5'b01001;
    else if (lu)           exp = 5'b01010;
    else                   exp = 5'b10000;
    chk("ctl", 32'({bus.pc_write, bus.hold, bus.IF_flush, bus.id_ex_flush, bus.ex_hold}),
        32'(exp));
    if (m_valid) begin
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      chk("mdu_timeout", 32'(bus.mdu_timeout), 32'(m_to));
    end
    if (r) begin
      m_squash = 0; m_busy = 0; m_wait = 0; m_to = 0; m_stall = 0; m_valid = 1;
    end else begin
      if (m_squash > 0) m_squash--;
      else if (m_busy) begin
        if (dn) m_busy = 0;
        else begin
          m_wait++;
          if (m_wait >= TMO) m_to = 1;
        end
      end else if (br) m_squash = RB;
      else if (ms) begin
        m_busy = 1; m_wait = 0;
      end
      if (!exp[4] && m_stall < SMAX) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit dn);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, dn, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.ex_branch_taken = 0; bus.ex_mdu_start = 0; bus.mdu_done = 0;
    bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    // reset
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    // load-use on rs2, then one clean cycle
    cycle(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 1, 1);
    idle(1, 0);
    // load to x0 never stalls
    cycle(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    // taken branch with a simultaneous load-use
    cycle(0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd1, 1, 0);
    idle(4, 0);
    // MDU finishing on its fifth cycle
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    idle(1, 1);
    // mdu_done outside MDU_WAIT is ignored
    idle(2, 1);
    // timeout, then reset in the middle of the wait
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(10, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    // random mix, long enough to saturate the stall counter
    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0),
            5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the IF/ID register and the downstream ID/EX and EX/MEM stage registers.
- Detects load-use hazards, taken-branch redirects and multi-cycle MDU (mul/div) operations.
- Drives pc_write, hold, IF_flush, id_ex_flush and ex_hold so the fetch/decode front end stalls or squashes correctly.
- Also keeps a saturating stall-cycle performance counter and a sticky MDU timeout flag.

Parameters:
- REDIRECT_BUBBLES, 1: extra cycles IF/ID is squashed after a taken branch. Range 0..7; covers instruction-memory latency.
- MDU_TIMEOUT, 64: MDU_WAIT cycles without mdu_done before mdu_timeout sets.
- CNT_W, 32: width of stall_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_mdu_start  in  1  EX instruction starts a multi-cycle MDU op
- mdu_done  in  1  MDU result valid this cycle
- pc_write  out  1  PC register load enable
- hold  out  1  IF/ID hold; IF/ID loads only when hold=0
- IF_flush  out  1  IF/ID squash; honoured by IF/ID only while hold=1
- id_ex_flush  out  1  insert a bubble into ID/EX
- ex_hold  out  1  freeze ID/EX and EX/MEM
- mdu_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is synchronous, active-high.
- While rst=1: pc_write=0, hold=1, IF_flush=1, id_ex_flush=1, ex_hold=0.
- On the first clock edge with rst=1: state←RUN, bubble counter←0, timeout counter←0, mdu_timeout←0, stall_cnt←0.
- Reset mid-MDU or mid-redirect abandons the operation with no residual stall.
- Output structure: outputs are combinational from the registered state plus current inputs (Mealy), so there is zero-cycle hazard response.
- Flush encoding: a squash of IF/ID is always hold=1 with IF_flush=1. IF_flush=1 with hold=0 is never driven.
- Default in RUN with no event: pc_write=1, hold=0, IF_flush=0, id_ex_flush=0, ex_hold=0.
- lu (load-use hazard) = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, event priority branch > mdu_start > lu:
  - ex_branch_taken: pc_write=1, hold=1, IF_flush=1, id_ex_flush=1. If REDIRECT_BUBBLES>0, go to REDIRECT with counter←REDIRECT_BUBBLES-1; otherwise stay in RUN. lu and ex_mdu_start are ignored that cycle.
  - ex_mdu_start: pc_write=0, hold=1, IF_flush=0, ex_hold=1. Go to MDU_WAIT with the timeout counter←0.
  - lu only: pc_write=0, hold=1, IF_flush=0, id_ex_flush=1. Exactly one bubble; stay in RUN.
- REDIRECT:
  - Outputs: pc_write=1, hold=1, IF_flush=1, id_ex_flush=1.
  - Counter==0 → RUN; otherwise decrement.
  - Branch inputs are ignored, because the EX stage holds a bubble.
- MDU_WAIT:
  - Outputs while waiting: pc_write=0, hold=1, IF_flush=0, ex_hold=1.
  - mdu_done=1: in that same cycle ex_hold=0, pc_write=1 and hold=0; next state RUN.
  - mdu_done=0: timeout counter increments, saturating. When it reaches MDU_TIMEOUT, mdu_timeout←1 (sticky until rst) and the block stays in MDU_WAIT.
  - mdu_done is ignored in every state other than MDU_WAIT.
- stall_cnt: increments on every cycle with rst=0 and pc_write=0; saturates at all-ones.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum ctrl_state_t {RUN, REDIRECT, MDU_WAIT}
  - localparam REG_ZERO = 5'd0
  - localparam REG_W = 5
- One sub-module, load_use_detect: combinational lu computation, reusable by a future forwarding unit.

Test Plan:
- Reset: rst=1 for 2 cycles → pc_write=0, hold=1, IF_flush=1 every cycle. After release, RUN outputs pc_write=1, hold=0, and stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → pc_write=0, hold=1, id_ex_flush=1 for one cycle; stall_cnt=1.
- ex_rd=0 with ex_mem_read=1 and id_rs1=0 → no stall.
- Branch: REDIRECT_BUBBLES=2, ex_branch_taken=1 together with lu=1 → 3 consecutive cycles of hold=1, IF_flush=1, pc_write=1; lu ignored; back to RUN on cycle 4.
- MDU: ex_mdu_start=1, then mdu_done on cycle 5 → ex_hold=1 for cycles 1-4, released in cycle 5; stall_cnt=4; mdu_timeout=0.
- Timeout and reset mid-op: MDU_TIMEOUT=8, mdu_done never asserted → mdu_timeout=1 after 8 wait cycles. Then rst=1 for one cycle → RUN, mdu_timeout=0, stall_cnt=0.
